car_key_lock: RTL and testbench
===============================

# car_key_lock

Parametrised serial car-key receiver and checker, the next generation of the car-key shift circuit. A key is shifted in one bit per accepted `bit_valid`. After `NBITS_KEY` bits it is compared with `KEY_VALUE`: a match unlocks the ignition, a mismatch counts a failed attempt. `MAX_TRIES` consecutive failures force a timed lockout. The block sits between the switch/serial input logic and the ignition LED/status outputs of `top`.

## Interface
- `NBITS_KEY`, default 4: key length in bits; legal range ≥ 2.
- `KEY_VALUE`, default 'b1101: expected key, `NBITS_KEY` wide.
- `LSB_FIRST`, default 1: bit order. 1 means the first received bit lands in bit 0; 0 means the first received bit lands in bit `NBITS_KEY-1`.
- `MAX_TRIES`, default 3: consecutive failures that trigger lockout; legal range ≥ 1.
- `LOCKOUT_CYCLES`, default 8: cycles spent in lockout; legal range ≥ 1.
- `clk_2` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `bit_in` input 1: serial key bit.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `abort` input 1: discard a partially received key.
- `lock` input 1: relock while unlocked.
- `unlocked` output 1: ignition enabled.
- `locked_out` output 1: lockout active.
- `busy` output 1: key reception or check in progress.
- `fail_count` output $clog2(MAX_TRIES+1): consecutive failed attempts.

## Operation
- States: IDLE, RECV, CHECK, UNLOCKED, LOCKOUT.
- Reset (any state, mid-key or mid-lockout): state IDLE, shift register 0, bit counter 0, `fail_count` 0, timer 0. All outputs read 0 on the cycle after reset.
- Shift rule, applied on each accepted bit:
  - `LSB_FIRST`=1: sr <= {bit_in, sr[N-1:1]}.
  - `LSB_FIRST`=0: sr <= {sr[N-2:0], bit_in}.
- IDLE:
  - `bit_valid`: shift the bit in, counter <= 1, go to RECV.
  - `abort` and `lock` are ignored.
- RECV:
  - `abort` has priority over a simultaneous `bit_valid`: go to IDLE, clear sr and counter, `fail_count` unchanged.
  - Otherwise `bit_valid` shifts the bit in and increments the counter. The bit that makes the count equal `NBITS_KEY` moves the state to CHECK.
  - Cycles with no `bit_valid` hold state; there is no timeout.
- CHECK, exactly one cycle; `bit_valid`, `abort` and `lock` are ignored:
  - sr == `KEY_VALUE`: go to UNLOCKED, `fail_count` <= 0.
  - Mismatch with `fail_count`+1 == `MAX_TRIES`: go to LOCKOUT, `fail_count` <= `MAX_TRIES`, timer <= `LOCKOUT_CYCLES`-1.
  - Mismatch otherwise: go to IDLE, `fail_count` <= `fail_count`+1.
  - In every case sr and counter are cleared.
- UNLOCKED: `lock` returns to IDLE. `bit_valid` and `abort` are ignored.
- LOCKOUT: all inputs are ignored and the timer decrements each cycle. When the timer reads 0, go to IDLE and set `fail_count` <= 0.
- Output decode (Moore, from the state register):
  - `unlocked` = (state==UNLOCKED).
  - `locked_out` = (state==LOCKOUT).
  - `busy` = (state==RECV or CHECK).

## Timing
- Final key bit sampled at edge k: CHECK during cycle k..k+1, result state at edge k+1. `unlocked` or `locked_out` rises 2 edges after the last bit; an unlocked result is 2 cycles of latency.
- Bits may arrive back-to-back, one per cycle. A bit presented during CHECK is dropped and is not the first bit of the next key.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles; `locked_out` is high for exactly that many cycles.
- `lock` asserted at edge j in UNLOCKED: `unlocked` is low after edge j, and a new key bit is accepted from edge j+1.
- No combinational path from inputs to outputs.

## Structure
- Package `car_key_pkg`: `state_t` enum (IDLE, RECV, CHECK, UNLOCKED, LOCKOUT) and the default parameter constants.
- Sub-module `key_shift_rx`: shift register plus bit counter, with parameters `NBITS_KEY` and `LSB_FIRST`.
  - Inputs: `clk_2`, `reset`, `clear`, `shift`, `bit_in`.
  - Outputs: `sr`, `last_bit` (this shift completes the key).
- Top FSM, fail counter and lockout timer live in `car_key_lock`.

## Test plan
- Defaults, bits 1,0,1,1 on consecutive cycles (LSB first, sr=1101) → `unlocked`=1 two edges after the 4th bit, `fail_count`=0; then `lock` → `unlocked`=0.
- Three wrong keys, 0000 each → `fail_count` steps 1, 2, then `locked_out`=1 for exactly 8 cycles. `bit_valid` pulses during lockout have no effect. Afterwards state is IDLE with `fail_count`=0.
- Two bits sent, then `abort` with a simultaneous `bit_valid`=1 → back to IDLE, `fail_count` unchanged. A following correct key unlocks.
- `LSB_FIRST`=0, `NBITS_KEY`=8, `KEY_VALUE`=8'hA5, bits sent MSB-first 1,0,1,0,0,1,0,1 with idle gaps between bits → unlock.
- `reset` during RECV, and separately during cycle 4 of LOCKOUT → next cycle all outputs 0, `fail_count`=0. A correct key then unlocks.

Source files
------------

// File: rtl/car_key_pkg.sv
// Shared state encoding and default configuration for the serial car-key lock.
package car_key_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam int unsigned NBITS_KEY_DEF      = 4;
  localparam logic [3:0]  KEY_VALUE_DEF      = 4'b1101;
  localparam bit          LSB_FIRST_DEF      = 1'b1;
  localparam int unsigned MAX_TRIES_DEF      = 3;
  localparam int unsigned LOCKOUT_CYCLES_DEF = 8;

  // Width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_shift_rx.sv
// Serial key shift register with bit counter; flags the shift that completes a key.
module key_shift_rx #(
  parameter int unsigned NBITS_KEY = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 bit_in,
  output logic [NBITS_KEY-1:0] sr,
  output logic                 last_bit
);

  localparam int unsigned CW = $clog2(NBITS_KEY + 1);

  logic [NBITS_KEY-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift) begin
      if (LSB_FIRST) begin
        sr_d = {bit_in, sr_q[NBITS_KEY-1:1]};
      end else begin
        sr_d = {sr_q[NBITS_KEY-2:0], bit_in};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr       = sr_q;
  assign last_bit = shift && !clear && (cnt_q == CW'(NBITS_KEY - 1));

endmodule

// File: rtl/car_key_lock.sv
// Serial car-key checker: receive, compare, unlock, and timed lockout after repeated failures.
module car_key_lock
  import car_key_pkg::*;
#(
  parameter int unsigned          NBITS_KEY      = NBITS_KEY_DEF,
  parameter logic [NBITS_KEY-1:0] KEY_VALUE      = NBITS_KEY'(KEY_VALUE_DEF),
  parameter bit                   LSB_FIRST      = LSB_FIRST_DEF,
  parameter int unsigned          MAX_TRIES      = MAX_TRIES_DEF,
  parameter int unsigned          LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic                           clk_2,
  input  logic                           reset,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  input  logic                           abort,
  input  logic                           lock,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           busy,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

  localparam int unsigned FW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TW = idx_width(LOCKOUT_CYCLES);

  state_t          state_q, state_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic                 rx_shift;
  logic                 rx_clear;
  logic                 rx_last;
  logic [NBITS_KEY-1:0] rx_sr;

  key_shift_rx #(
    .NBITS_KEY (NBITS_KEY),
    .LSB_FIRST (LSB_FIRST)
  ) u_rx (
    .clk_2    (clk_2),
    .reset    (reset),
    .clear    (rx_clear),
    .shift    (rx_shift),
    .bit_in   (bit_in),
    .sr       (rx_sr),
    .last_bit (rx_last)
  );

  // Shift/clear are decoded apart from the next-state logic so that
  // last_bit (a function of shift) feeds the FSM without a feedback loop.
  always_comb begin
    rx_shift = 1'b0;
    rx_clear = 1'b0;
    unique case (state_q)
      IDLE:    rx_shift = bit_valid;
      RECV: begin
        rx_clear = abort;
        rx_shift = bit_valid && !abort;
      end
      CHECK:   rx_clear = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (bit_valid) state_d = RECV;
      end
      RECV: begin
        if (abort)        state_d = IDLE;
        else if (rx_last) state_d = CHECK;
      end
      CHECK: begin
        if (rx_sr == KEY_VALUE) begin
          state_d = UNLOCKED;
          fail_d  = '0;
        end else if (fail_q == FW'(MAX_TRIES - 1)) begin
          state_d = LOCKOUT;
          fail_d  = FW'(MAX_TRIES);
          timer_d = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = IDLE;
          fail_d  = fail_q + 1'b1;
        end
      end
      UNLOCKED: begin
        if (lock) state_d = IDLE;
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  assign unlocked   = (state_q == UNLOCKED);
  assign locked_out = (state_q == LOCKOUT);
  assign busy       = (state_q == RECV) || (state_q == CHECK);
  assign fail_count = fail_q;

endmodule

// File: tb/tb_car_key_lock.sv
// Directed bench for car_key_lock: default LSB-first instance plus an 8-bit MSB-first instance.
module tb_car_key_lock;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic       reset, bit_in, bit_valid, abort, lock;
  logic       unlocked, locked_out, busy;
  logic [1:0] fail_count;

  logic       b_bit_in, b_bit_valid, b_abort, b_lock;
  logic       b_unlocked, b_locked_out, b_busy;
  logic [1:0] b_fail_count;

  int n_checks = 0;
  int n_fails  = 0;

  car_key_lock dut_a (
    .clk_2      (clk_2),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .abort      (abort),
    .lock       (lock),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .busy       (busy),
    .fail_count (fail_count)
  );

  car_key_lock #(
    .NBITS_KEY (8),
    .KEY_VALUE (8'hA5),
    .LSB_FIRST (1'b0)
  ) dut_b (
    .clk_2      (clk_2),
    .reset      (reset),
    .bit_in     (b_bit_in),
    .bit_valid  (b_bit_valid),
    .abort      (b_abort),
    .lock       (b_lock),
    .unlocked   (b_unlocked),
    .locked_out (b_locked_out),
    .busy       (b_busy),
    .fail_count (b_fail_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  // Sends four bits in arrival order key[0], key[1], ...; optionally keeps
  // bit_valid high through the CHECK cycle, then lets the result edge pass.
  task automatic send_key_a(input logic [3:0] key, input logic hold_in_check);
    for (int unsigned i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = key[i];
      tick();
    end
    bit_valid = hold_in_check;
    bit_in    = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  initial begin
    int unsigned hi_cycles;
    int unsigned guard;
    logic [7:0]  key_b;

    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0; lock = 1'b0;
    b_bit_in = 1'b0; b_bit_valid = 1'b0; b_abort = 1'b0; b_lock = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_unlocked", unlocked, 0);
    check("reset_locked_out", locked_out, 0);
    check("reset_busy", busy, 0);
    check("reset_fail_count", fail_count, 0);
    check("reset_b_busy", b_busy, 0);

    // Correct key 1,0,1,1 with explicit latency checks.
    bit_valid = 1'b1;
    bit_in = 1'b1; tick();
    check("rx_busy_first_bit", busy, 1);
    bit_in = 1'b0; tick();
    bit_in = 1'b1; tick();
    bit_in = 1'b1; tick();
    bit_valid = 1'b0;
    check("check_cycle_busy", busy, 1);
    check("check_cycle_not_unlocked", unlocked, 0);
    tick();
    check("good_key_unlocked", unlocked, 1);
    check("good_key_busy_low", busy, 0);
    check("good_key_fail_zero", fail_count, 0);
    bit_valid = 1'b1; abort = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0; abort = 1'b0;
    check("unlocked_ignores_bits", unlocked, 1);
    lock = 1'b1; tick(); lock = 1'b0;
    check("relock_unlocked_low", unlocked, 0);
    check("relock_idle", busy, 0);

    // Three wrong keys; first one also offers a bit during CHECK.
    send_key_a(4'b0000, 1'b1);
    check("wrong1_fail_count", fail_count, 1);
    check("check_bit_dropped", busy, 0);
    send_key_a(4'b0000, 1'b0);
    check("wrong2_fail_count", fail_count, 2);
    check("wrong2_not_locked", locked_out, 0);
    send_key_a(4'b0000, 1'b0);
    check("wrong3_locked_out", locked_out, 1);
    check("lockout_fail_count", fail_count, 3);
    hi_cycles = 0;
    guard     = 0;
    while (locked_out && guard < 20) begin
      hi_cycles++;
      bit_valid = guard[0];
      bit_in    = 1'b1;
      tick();
      guard++;
    end
    bit_valid = 1'b0;
    check("lockout_length", hi_cycles, 8);
    check("after_lockout_fail_zero", fail_count, 0);
    check("after_lockout_idle", busy, 0);
    check("after_lockout_not_unlocked", unlocked, 0);

    // Abort with simultaneous bit_valid keeps fail_count; then a good key.
    send_key_a(4'b0110, 1'b0);
    check("pre_abort_fail_count", fail_count, 1);
    bit_valid = 1'b1;
    bit_in = 1'b1; tick();
    bit_in = 1'b0; tick();
    check("pre_abort_busy", busy, 1);
    abort = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_fail_unchanged", fail_count, 1);
    send_key_a(4'b1101, 1'b0);
    check("post_abort_unlock", unlocked, 1);
    check("post_abort_fail_zero", fail_count, 0);
    lock = 1'b1; tick(); lock = 1'b0;

    // 8-bit MSB-first key A5 with idle gaps.
    key_b = 8'hA5;
    for (int unsigned i = 0; i < 8; i++) begin
      b_bit_valid = 1'b1;
      b_bit_in    = key_b[7 - i];
      tick();
      b_bit_valid = 1'b0;
      b_bit_in    = 1'b0;
      if (i < 7) begin
        tick();
        tick();
        check("b_busy_in_gap", b_busy, 1);
      end
    end
    check("b_check_not_unlocked", b_unlocked, 0);
    tick();
    check("b_unlocked", b_unlocked, 1);
    check("b_fail_zero", b_fail_count, 0);
    b_lock = 1'b1; tick(); b_lock = 1'b0;
    check("b_relock", b_unlocked, 0);

    // Reset during RECV.
    bit_valid = 1'b1;
    bit_in = 1'b1; tick();
    bit_in = 1'b0; tick();
    bit_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_recv_busy", busy, 0);
    check("rst_recv_unlocked", unlocked, 0);
    check("rst_recv_locked_out", locked_out, 0);
    check("rst_recv_fail", fail_count, 0);
    send_key_a(4'b1101, 1'b0);
    check("rst_recv_then_unlock", unlocked, 1);
    lock = 1'b1; tick(); lock = 1'b0;

    // Reset during the fourth lockout cycle.
    send_key_a(4'b0001, 1'b0);
    send_key_a(4'b0001, 1'b0);
    send_key_a(4'b0001, 1'b0);
    check("rst_lock_entered", locked_out, 1);
    tick(); tick(); tick();
    check("rst_lock_still_locked", locked_out, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_lock_locked_out", locked_out, 0);
    check("rst_lock_busy", busy, 0);
    check("rst_lock_unlocked", unlocked, 0);
    check("rst_lock_fail", fail_count, 0);
    send_key_a(4'b1101, 1'b0);
    check("rst_lock_then_unlock", unlocked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
